// File: rtl/hq_bmat_mult.sv
// hq_bmat_mult: complex fixed-point matrix product OUT = H (NR x NT) * B (NT x NC).
// One output element per clock through a two-stage pipeline (products, then
// sum/round/reduce). Completed columns are streamed on col_*; the full result
// is held on out_* until the next accepted start.
// Build option: define HQB_SAT_EN to saturate results to DW bits; otherwise
// results wrap (two's complement). Latency is identical either way.
module hq_bmat_mult #(
  parameter int DW = 16,
  parameter int FW = 8,
  parameter int NR = 4,
  parameter int NT = 2,
  parameter int NC = 2,
  // Derived column-index width; leave at its default.
  parameter int CW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [NR*NT*DW-1:0]   h_r_i,
  input  logic [NR*NT*DW-1:0]   h_i_i,
  input  logic [NT*NC*DW-1:0]   b_r_i,
  input  logic [NT*NC*DW-1:0]   b_i_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  out_valid_o,
  output logic [NR*NC*DW-1:0]   out_r_o,
  output logic [NR*NC*DW-1:0]   out_i_o,
  output logic                  col_valid_o,
  output logic [CW-1:0]         col_idx_o,
  output logic [NR*DW-1:0]      col_r_o,
  output logic [NR*DW-1:0]      col_i_o
);

  localparam int RW = (NR > 1) ? $clog2(NR) : 1;
  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + $clog2(NT) + 1;
  localparam logic signed [SW-1:0] HALF = SW'(1) << (FW - 1);
`ifdef HQB_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t                  state_q;
  logic [NR*NT*DW-1:0]     h_r_q, h_i_q;
  logic [NT*NC*DW-1:0]     b_r_q, b_i_q;
  logic [RW-1:0]           row_q, row1_q;
  logic [CW-1:0]           col_q, col1_q;
  logic                    v1_q;
  logic signed [PW-1:0]    prod_r_q [NT];
  logic signed [PW-1:0]    prod_i_q [NT];
  logic signed [PW-1:0]    prod_r_d [NT];
  logic signed [PW-1:0]    prod_i_d [NT];
  logic signed [SW-1:0]    sum_r_d, sum_i_d;
  logic [DW-1:0]           res_r_d, res_i_d;
  logic                    busy_q, done_q, out_valid_q, col_valid_q;
  logic [NR*NC*DW-1:0]     out_r_q, out_i_q;
  logic [CW-1:0]           col_idx_q;
  logic [NR*DW-1:0]        col_r_q, col_i_q;

  // Round half up at the binary point, then reduce the wide sum to DW bits.
  function automatic logic [DW-1:0] round_reduce(input logic signed [SW-1:0] s);
`ifdef HQB_SAT_EN
    logic signed [SW-1:0] r;
    r = (s + HALF) >>> FW;
    if (r > SAT_MAX) begin
      round_reduce = SAT_MAX[DW-1:0];
    end else if (r < SAT_MIN) begin
      round_reduce = SAT_MIN[DW-1:0];
    end else begin
      round_reduce = r[DW-1:0];
    end
`else
    round_reduce = DW'((s + HALF) >>> FW);
`endif
  endfunction

  // Stage-1 operands: NT complex products for the element being issued.
  always_comb begin
    for (int j = 0; j < NT; j++) begin
      prod_r_d[j] = $signed(h_r_q[(int'(row_q)*NT + j)*DW +: DW]) * $signed(b_r_q[(j*NC + int'(col_q))*DW +: DW])
                  - $signed(h_i_q[(int'(row_q)*NT + j)*DW +: DW]) * $signed(b_i_q[(j*NC + int'(col_q))*DW +: DW]);
      prod_i_d[j] = $signed(h_r_q[(int'(row_q)*NT + j)*DW +: DW]) * $signed(b_i_q[(j*NC + int'(col_q))*DW +: DW])
                  + $signed(h_i_q[(int'(row_q)*NT + j)*DW +: DW]) * $signed(b_r_q[(j*NC + int'(col_q))*DW +: DW]);
    end
  end

  // Stage-2 operands: widened sum of the registered products, rounded and reduced.
  always_comb begin
    sum_r_d = '0;
    sum_i_d = '0;
    for (int j = 0; j < NT; j++) begin
      sum_r_d = sum_r_d + SW'(prod_r_q[j]);
      sum_i_d = sum_i_d + SW'(prod_i_q[j]);
    end
    res_r_d = round_reduce(sum_r_d);
    res_i_d = round_reduce(sum_i_d);
  end

  // Control FSM, operand capture, stage-1 product registers and stage-2 write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      h_r_q       <= '0;
      h_i_q       <= '0;
      b_r_q       <= '0;
      b_i_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      row1_q      <= '0;
      col1_q      <= '0;
      v1_q        <= 1'b0;
      for (int j = 0; j < NT; j++) begin
        prod_r_q[j] <= '0;
        prod_i_q[j] <= '0;
      end
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      col_valid_q <= 1'b0;
      col_idx_q   <= '0;
      col_r_q     <= '0;
      col_i_q     <= '0;
    end else begin
      done_q      <= 1'b0;
      col_valid_q <= 1'b0;
      // Stage 2: write the element whose products were registered last edge.
      if (v1_q) begin
        out_r_q[(int'(col1_q)*NR + int'(row1_q))*DW +: DW] <= res_r_d;
        out_i_q[(int'(col1_q)*NR + int'(row1_q))*DW +: DW] <= res_i_d;
        if (row1_q == RW'(NR - 1)) begin
          // Last row of the column arrives now; earlier rows are already in out_*.
          col_valid_q <= 1'b1;
          col_idx_q   <= col1_q;
          for (int k = 0; k < NR; k++) begin
            col_r_q[k*DW +: DW] <= (k == NR - 1) ? res_r_d : out_r_q[(int'(col1_q)*NR + k)*DW +: DW];
            col_i_q[k*DW +: DW] <= (k == NR - 1) ? res_i_d : out_i_q[(int'(col1_q)*NR + k)*DW +: DW];
          end
        end
      end
      case (state_q)
        S_IDLE: begin
          v1_q <= 1'b0;
          if (start_i) begin
            h_r_q       <= h_r_i;
            h_i_q       <= h_i_i;
            b_r_q       <= b_r_i;
            b_i_q       <= b_i_i;
            row_q       <= '0;
            col_q       <= '0;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
            state_q     <= S_CALC;
          end
        end
        S_CALC: begin
          v1_q   <= 1'b1;
          row1_q <= row_q;
          col1_q <= col_q;
          for (int j = 0; j < NT; j++) begin
            prod_r_q[j] <= prod_r_d[j];
            prod_i_q[j] <= prod_i_d[j];
          end
          if (row_q == RW'(NR - 1)) begin
            row_q <= '0;
            if (col_q == CW'(NC - 1)) begin
              state_q <= S_FLUSH;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        S_FLUSH: begin
          // The final element is being written this edge.
          v1_q        <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign out_valid_o = out_valid_q;
  assign out_r_o     = out_r_q;
  assign out_i_o     = out_i_q;
  assign col_valid_o = col_valid_q;
  assign col_idx_o   = col_idx_q;
  assign col_r_o     = col_r_q;
  assign col_i_o     = col_i_q;

endmodule

// File: tb/tb_hq_bmat_mult.sv
// Self-checking bench for hq_bmat_mult (default parameters). Expected columns
// and matrices come from an integer reference model and are queued when a run
// is started; a negedge monitor pops and compares them as the DUT emits them.
module tb_hq_bmat_mult;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int NR = 4;
  localparam int NT = 2;
  localparam int NC = 2;
  localparam int N  = NR * NC;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [NR*NT*DW-1:0] h_r, h_i;
  logic [NT*NC*DW-1:0] b_r, b_i;
  logic busy, done, out_valid, col_valid;
  logic [NR*NC*DW-1:0] out_r, out_i;
  logic [0:0] col_idx;
  logic [NR*DW-1:0] col_r, col_i;

  hq_bmat_mult dut (
    .clk(clk), .rst(rst), .start_i(start),
    .h_r_i(h_r), .h_i_i(h_i), .b_r_i(b_r), .b_i_i(b_i),
    .busy_o(busy), .done_o(done), .out_valid_o(out_valid),
    .out_r_o(out_r), .out_i_o(out_i),
    .col_valid_o(col_valid), .col_idx_o(col_idx),
    .col_r_o(col_r), .col_i_o(col_i)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [NR*DW-1:0] r; logic [NR*DW-1:0] i; } col_t;
  typedef struct { logic [NR*NC*DW-1:0] r; logic [NR*NC*DW-1:0] i; } mat_t;
  col_t col_q[$];
  mat_t mat_q[$];
  col_t cv;
  mat_t mv;
  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_elem(input longint s);
    longint r;
    r = (s + (longint'(1) << (FW - 1))) >>> FW;
`ifdef HQB_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[DW-1:0];
  endfunction

  task automatic push_expect();
    col_t c;
    mat_t m;
    longint ar, ai, br, bi, sr, si;
    m.r = '0; m.i = '0;
    for (int cc = 0; cc < NC; cc++) begin
      c.idx = cc; c.r = '0; c.i = '0;
      for (int k = 0; k < NR; k++) begin
        sr = 0; si = 0;
        for (int j = 0; j < NT; j++) begin
          ar = longint'($signed(h_r[(k*NT+j)*DW +: DW]));
          ai = longint'($signed(h_i[(k*NT+j)*DW +: DW]));
          br = longint'($signed(b_r[(j*NC+cc)*DW +: DW]));
          bi = longint'($signed(b_i[(j*NC+cc)*DW +: DW]));
          sr += ar * br - ai * bi;
          si += ar * bi + ai * br;
        end
        c.r[k*DW +: DW] = ref_elem(sr);
        c.i[k*DW +: DW] = ref_elem(si);
        m.r[(cc*NR+k)*DW +: DW] = ref_elem(sr);
        m.i[(cc*NR+k)*DW +: DW] = ref_elem(si);
      end
      col_q.push_back(c);
    end
    mat_q.push_back(m);
  endtask

  task automatic clear_in();
    h_r = '0; h_i = '0; b_r = '0; b_i = '0;
  endtask

  task automatic load_t1();
    clear_in();
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < NT; j++) begin
        h_r[(k*NT+j)*DW +: DW] = 16'((k + 1) * 256);
        h_i[(k*NT+j)*DW +: DW] = 16'(16 * k);
      end
    b_r[(0*NC+0)*DW +: DW] = 16'h0100;
    b_r[(1*NC+1)*DW +: DW] = 16'hFF00;
  endtask

  task automatic start_run(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    check({tag, "_busy_e0"}, 128'(busy), 128'(1'b1));
    check({tag, "_ov_e0"}, 128'(out_valid), 128'(1'b0));
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({tag, "_done_seen"}, 128'(seen), 128'(1'b1));
  endtask

  task automatic check_t1(input string tag);
    logic [DW-1:0] e;
    for (int k = 0; k < NR; k++) begin
      e = 16'((k + 1) * 256);
      check({tag, "_c0r"}, 128'(out_r[k*DW +: DW]), 128'(e));
      e = 16'(16 * k);
      check({tag, "_c0i"}, 128'(out_i[k*DW +: DW]), 128'(e));
      e = 16'(-((k + 1) * 256));
      check({tag, "_c1r"}, 128'(out_r[(NR+k)*DW +: DW]), 128'(e));
      e = 16'(-(16 * k));
      check({tag, "_c1i"}, 128'(out_i[(NR+k)*DW +: DW]), 128'(e));
    end
  endtask

  // Scoreboard monitor: compare emitted columns and completed matrices.
  always @(negedge clk) begin
    if (!rst && col_valid) begin
      if (col_q.size() == 0) begin
        check("col_unexpected", 128'(1'b1), 128'(1'b0));
      end else begin
        cv = col_q.pop_front();
        check("col_idx", 128'(col_idx), 128'(cv.idx));
        check("col_r", 128'(col_r), 128'(cv.r));
        check("col_i", 128'(col_i), 128'(cv.i));
        check("col_edge", 128'(cyc - t0), 128'(NR * (cv.idx + 1) + 1));
      end
    end
    if (!rst && done) begin
      if (mat_q.size() == 0) begin
        check("done_unexpected", 128'(1'b1), 128'(1'b0));
      end else begin
        mv = mat_q.pop_front();
        check("out_r", out_r, mv.r);
        check("out_i", out_i, mv.i);
        check("done_edge", 128'(cyc - t0), 128'(N + 1));
        check("done_busy", 128'(busy), 128'(1'b0));
        check("done_ov", 128'(out_valid), 128'(1'b1));
      end
    end
  end

  initial begin
    logic [DW-1:0] sat_exp;
    rst = 1'b1;
    start = 1'b0;
    clear_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_done", 128'(done), 128'(1'b0));
    check("rst_ov", 128'(out_valid), 128'(1'b0));
    check("rst_colv", 128'(col_valid), 128'(1'b0));
    check("rst_out", out_r | out_i, 128'(1'b0));
    check("rst_col", 128'(col_r | col_i), 128'(1'b0));
    rst = 1'b0;

    // Test 1: identity / negation columns.
    load_t1();
    push_expect();
    start_run("t1");
    wait_done("t1");
    check_t1("t1");

    // Test 2: complex product (1+j)(1-j) = 2.
    clear_in();
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < NT; j++) begin
        h_r[(k*NT+j)*DW +: DW] = 16'h0100;
        h_i[(k*NT+j)*DW +: DW] = 16'h0100;
      end
    b_r[0 +: DW] = 16'h0100;
    b_i[0 +: DW] = 16'hFF00;
    push_expect();
    start_run("t2");
    wait_done("t2");
    for (int k = 0; k < NR; k++) begin
      check("t2_c0r", 128'(out_r[k*DW +: DW]), 128'(16'h0200));
      check("t2_c0i", 128'(out_i[k*DW +: DW]), 128'(16'h0000));
      check("t2_c1r", 128'(out_r[(NR+k)*DW +: DW]), 128'(16'h0000));
    end

    // Test 3: half-LSB rounds up.
    clear_in();
    h_r[0 +: DW] = 16'h0001;
    b_r[0 +: DW] = 16'h0080;
    push_expect();
    start_run("t3");
    wait_done("t3");
    check("t3_round", 128'(out_r[0 +: DW]), 128'(16'h0001));

    // Test 4: overflow, wrap or saturate.
    clear_in();
    for (int i = 0; i < NR * NT; i++) h_r[i*DW +: DW] = 16'h7F00;
    for (int i = 0; i < NT * NC; i++) b_r[i*DW +: DW] = 16'h0100;
`ifdef HQB_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hFE00;
`endif
    push_expect();
    start_run("t4");
    wait_done("t4");
    for (int e = 0; e < N; e++) check("t4_ovf", 128'(out_r[e*DW +: DW]), 128'(sat_exp));

    // Test 5a: start pulsed mid-run with different operands is ignored.
    load_t1();
    push_expect();
    start_run("t5a");
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    h_r = ~h_r;
    b_i = {(NT*NC*DW){1'b1}};
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t5a");
    check_t1("t5a");

    // Test 5b: start held through the done cycle launches a second run.
    load_t1();
    push_expect();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    clear_in();
    h_r[0 +: DW] = 16'h0300;
    h_i[DW +: DW] = 16'h0040;
    b_r[0 +: DW] = 16'h0200;
    b_r[(1*NC+1)*DW +: DW] = 16'h0180;
    b_i[(1*NC+0)*DW +: DW] = 16'hFFC0;
    push_expect();
    wait_done("t5b_a");
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    check("t5b_ov_drop", 128'(out_valid), 128'(1'b0));
    check("t5b_busy2", 128'(busy), 128'(1'b1));
    wait_done("t5b_b");

    // Test 6: reset mid-run aborts; a fresh run still gives test 1.
    load_t1();
    start_run("t6");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_busy", 128'(busy), 128'(1'b0));
    check("t6_done", 128'(done), 128'(1'b0));
    check("t6_ov", 128'(out_valid), 128'(1'b0));
    check("t6_out", out_r | out_i, 128'(1'b0));
    check("t6_col", 128'(col_r | col_i), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    push_expect();
    start_run("t6r");
    wait_done("t6r");
    check_t1("t6r");

    repeat (3) @(negedge clk);
    check("sb_col_drain", 128'(col_q.size()), 128'(0));
    check("sb_mat_drain", 128'(mat_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
